// File: rtl/edge_evt_pkg.sv
// Shared defaults and helpers for the edge event arbiter slice.
package edge_evt_pkg;

    localparam int N_DEFAULT     = 4;
    localparam int ID_W_DEFAULT  = $clog2(N_DEFAULT);
    localparam int CNT_W_DEFAULT = 8;

    // Largest value a cnt_w-bit saturating counter may hold.
    function automatic longint unsigned drop_max(input int cnt_w);
        return (longint'(1) << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping mod N.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic            grant_valid_o,
    output logic [ID_W-1:0] grant_idx_o
);

    logic [ID_W-1:0] idx_v;

    // Walk the offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx_v         = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx_v = ID_W'((int'(ptr_i) + k) % N);
            if (req_i[idx_v]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = idx_v;
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Rising-edge detector with sticky per-channel pending flags, round-robin
// scheduled onto a single valid/ready event slot, plus a saturating drop counter.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int ID_W  = $clog2(N),
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     data_in,
    input  logic [N-1:0]     enable,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    input  logic             evt_ready,
    output logic [N-1:0]     pending,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [CNT_W-1:0] DROP_MAX_V = CNT_W'(drop_max(CNT_W));

    logic [N-1:0]     prev_q;
    logic [N-1:0]     pending_q,   pending_d;
    logic             evt_valid_q, evt_valid_d;
    logic [ID_W-1:0]  evt_id_q,    evt_id_d;
    logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0] drop_cnt_q,  drop_cnt_d;

    logic [N-1:0]     edge_w;
    logic [N-1:0]     load_w;
    logic [N-1:0]     drop_w;
    logic             grant_valid;
    logic [ID_W-1:0]  grant_idx;
    logic             slot_free;
    logic             do_load;
    logic [CNT_W+4:0] sum_ext;

    assign edge_w    = data_in & ~prev_q & enable;
    assign slot_free = ~evt_valid_q | evt_ready;
    assign do_load   = slot_free & grant_valid;

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req_i         (pending_q),
        .ptr_i         (rr_ptr_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign load_w[gi] = do_load && (int'(grant_idx) == gi);
        end
    endgenerate

    // A fresh edge on the channel being loaded re-arms it rather than being lost.
    assign pending_d = edge_w | (pending_q & ~load_w);
    assign drop_w    = edge_w & pending_q & ~load_w;

    always_comb begin
        sum_ext = {5'b0, drop_cnt_q};
        for (int i = 0; i < N; i++) begin
            sum_ext = sum_ext + (CNT_W + 5)'(drop_w[i]);
        end
        if (sum_ext > {5'b0, DROP_MAX_V}) begin
            drop_cnt_d = DROP_MAX_V;
        end else begin
            drop_cnt_d = sum_ext[CNT_W-1:0];
        end
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (do_load) begin
            evt_valid_d = 1'b1;
            evt_id_d    = grant_idx;
            rr_ptr_d    = (int'(grant_idx) == N - 1) ? '0 : grant_idx + ID_W'(1);
        end else if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q      <= '0;
            pending_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            rr_ptr_q    <= '0;
            drop_cnt_q  <= '0;
        end else begin
            prev_q      <= data_in;
            pending_q   <= pending_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            rr_ptr_q    <= rr_ptr_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Detects rising edges on N independent single-bit inputs and latches each edge as a sticky pending request per channel.
- Round-robin schedules the pending events onto one shared valid/ready event channel, one channel ID per transfer.
- Counts events lost to overflow with a saturating counter.
- Sits between raw level/strobe sources and a single downstream event consumer, such as an interrupt or log unit.

Parameters:
- N, 4, number of input channels (2..16).
- ID_W, $clog2(N), width of evt_id.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset: synchronous, active-low.
- data_in  input  N  per-channel level inputs, already synchronous to clk.
- enable  input  N  per-channel edge-detect enable mask.
- evt_valid  output  1  event available.
- evt_id  output  ID_W  channel index of presented event.
- evt_ready  input  1  consumer accepts event when evt_valid&evt_ready.
- pending  output  N  registered sticky pending flags.
- drop_cnt  output  CNT_W  saturating count of dropped edges.

Behaviour:
- Reset (rst_n=0 at a clk edge): prev, pending, evt_valid, evt_id, drop_cnt and rr_ptr all clear to 0. Reset mid-transfer discards the presented event and all pending events.
- Edge detect per channel i:
  - prev[i] <= data_in[i] every non-reset cycle, regardless of enable.
  - edge[i] = data_in[i] & ~prev[i] & enable[i].
  - Because prev clears on reset, a line held high through reset release yields one edge in the first post-reset cycle.
- Pending update per channel, each cycle:
  - load[i]=1 when channel i is selected into the output register this cycle.
  - Next pending[i] = edge[i] | (pending[i] & ~load[i]).
  - drop[i] = edge[i] & pending[i] & ~load[i]. The edge is lost and pending stays 1.
  - An edge coinciding with load[i] is not a drop; pending[i] remains 1 as a new event.
- Output slot is a single register:
  - It may load when evt_valid=0, or when evt_valid&evt_ready in the same cycle.
  - If a load is allowed and pending is nonzero, select channel g via round-robin. Then evt_id<=g, evt_valid<=1, load[g]=1, rr_ptr<=(g+1) mod N.
  - If evt_valid&evt_ready and pending is zero, evt_valid<=0.
  - If evt_valid=1 and evt_ready=0, evt_valid and evt_id hold stable. No load occurs.
- Round-robin: search indices rr_ptr, rr_ptr+1, ... wrapping mod N; the first set pending bit wins. rr_ptr=0 after reset, so channel 0 wins first.
- Latency:
  - data_in[i] sampled 1 at edge k (prev 0): pending[i]=1 after edge k.
  - If the slot is free, evt_valid=1 with evt_id=i after edge k+1.
  - Back-to-back throughput is one event per cycle with evt_ready held 1.
- enable only masks new edges. Already-pending events on a disabled channel are still served. Re-enabling while data_in is high produces no edge.
- drop_cnt: each cycle add popcount(drop), saturating at 2^CNT_W-1. It never wraps and clears only on reset.
- pending output reflects the registered flags.

Decomposition:
- Package edge_evt_pkg holds the default N, ID_W and CNT_W constants and a DROP_MAX constant function for the saturation value.
- One sub-module, rr_pick: combinational, taking a pending vector plus pointer and giving grant_valid plus grant index. It is verified standalone for every pointer and request combination at N=4.

Test Plan:
- Reset release with data_in=4'b0001 high, enable=4'hF, evt_ready=1: pending[0]=1 after cycle 1, evt_valid=1 with evt_id=0 after cycle 2, then evt_valid=0. drop_cnt=0.
- Simultaneous edges on all 4 channels, evt_ready=1: evt_id sequence 0,1,2,3 on consecutive cycles. Next simultaneous burst with rr_ptr=0 again gives 0,1,2,3. After a single grant of channel 1, a burst on channels 0 and 3 gives 3 then 0.
- Backpressure: evt_ready=0 with events on channels 2 and 1 pending. evt_id stays 2 and valid stays 1 for 5 cycles. Raising ready yields 2 then 1.
- Overflow: channel 0 pending, ready=0, three further pulses on data_in[0] gives drop_cnt=3. Holding pulsing past 255 gives drop_cnt stuck at 255.
- Edge coinciding with load: channel 0 loads while a new edge arrives on data_in[0]. pending[0] stays 1, drop_cnt unchanged, and a second event with id 0 follows.
- Mask: enable[2]=0 while data_in[2] pulses gives no event. Set enable[2]=1 while data_in[2] is high gives no event; the next 0→1 transition gives one event. Assert rst_n=0 mid-backpressure: evt_valid=0, pending=0, drop_cnt=0 next cycle.
